aes_key_expand_serial: RTL and testbench
========================================

// Module: aes_key_expand_serial
// PURPOSE
// Byte-serial AES key-schedule generator for AES-128/192/256, selected per job by key_len.
// Has an internal FSM, Rcon/round counters and ready/valid flow control on both sides.
// Accepts the cipher key one byte per beat and streams every round-key byte (w[0]..w[4*(Nr+1)-1]).
// Sits between the AHB key register and the 8-bit cipher datapath.
// One bSbox instance is shared across all key sizes.
// PARAMETERS
// MAX_KEY_BITS  256  largest key supported (128|192|256); key_len above it -> treated as 128
// RND_W         4    width of rk_round
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      synchronous, active-high reset
// start      in   1      begin job (sampled only in IDLE)
// key_len    in   2      0=128 (Nk4,Nr10) 1=192 (Nk6,Nr12) 2=256 (Nk8,Nr14); 3 -> 128
// key_valid  in   1      key_in holds a valid key byte
// key_ready  out  1      block accepts key_in this cycle
// key_in     in   8      key byte, FIPS-197 order (byte 0 of w[0] first)
// rk_valid   out  1      rk_data valid
// rk_ready   in   1      downstream accepts rk_data
// rk_data    out  8      round-key byte
// rk_round   out  RND_W  round index of rk_data (0..Nr)
// rk_byte    out  4      byte index within the round key (0..15)
// rk_last    out  1      rk_data is the final byte of the schedule
// busy       out  1      FSM not IDLE
// BEHAVIOUR
// - Reset: state=IDLE. key_ready, rk_valid, rk_last and busy are 0. rk_data, rk_round and rk_byte are 0.
// - A beat transfers when valid&&ready. rk_valid never drops while held unaccepted.
// - rk_data, rk_round, rk_byte and rk_last stay stable while rk_valid&&!rk_ready.
// - IDLE: start=1 latches key_len -> LOAD. start outside IDLE is ignored.
// - LOAD: pass-through with zero latency: rk_valid=key_valid, key_ready=rk_ready, rk_data=key_in.
//   - Each transfer shifts the byte into a 4*Nk-byte window.
//   - After 4*Nk transfers -> EXPAND.
// - EXPAND: rk_valid=1 with data registered from the window; advances only on rk_ready.
//   - Byte j of w[i] = w[i-Nk][j] ^ t[j], where:
//     - i%Nk==0: t = SubWord(RotWord(w[i-1])), with Rcon XORed into byte 0 only.
//     - Nk==8 and i%Nk==4: t = SubWord(w[i-1]).
//     - otherwise: t = w[i-1].
//   - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36, advanced once per i%Nk==0 word.
//   - Each produced byte enters the window.
// - Counters: rk_byte increments per transfer and wraps 15->0. rk_round increments on that wrap.
//   - These counters run continuously across LOAD and EXPAND.
//   - For 192, key words span rounds 0-1; nothing resets at the LOAD/EXPAND boundary.
// - rk_last=1 on byte 4*(4*(Nr+1))-1. Total bytes: 176, 208 or 240.
// - After the rk_last transfer -> IDLE in the next cycle, with rk_valid=0.
// - No bubbles: with rk_ready held high in EXPAND, one byte per cycle.
// - Sustained LOAD+EXPAND takes exactly 176/208/240 transfer cycles.
// - Reset mid-job:
//   - Returns to IDLE next cycle.
//   - Discards window, counters and Rcon. Partial output is not completed.
// - Only the in-progress job's bytes are produced. key_in beats presented outside LOAD are not consumed (key_ready=0).
// TESTING
// - T1 AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 -> expected output:
//   - bytes 16-19 = a0 fa fe 17.
//   - bytes 172-175 = b6 63 0c a6 with rk_last on 175, rk_round=10, rk_byte=15.
// - T2 AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> expected output:
//   - bytes 24-27 = fe 0c 91 f7.
//   - bytes 204-207 = 01 00 22 02, rk_last on 207.
// - T3 AES-256, key 603deb10 ... 0914dff4 -> expected output:
//   - bytes 32-35 = 9b a3 54 11 (rk_round=2, rk_byte 0-3).
//   - last word 70 6c 63 1e, rk_last on 239.
// - T4 T1 repeated with random rk_ready and key_valid gaps -> checks:
//   - identical 176-byte stream.
//   - no rk_data change while stalled.
//   - key_ready tracks rk_ready in LOAD.
// - T5 rst asserted at EXPAND byte 100 -> checks:
//   - busy=0 and rk_valid=0 next cycle.
//   - fresh 256-bit job then produces the exact T3 stream.
// - T6 key_len=3, and start pulsed while busy -> checks:
//   - key_len=3 behaves as 128: 176 bytes, T1 values.
//   - start during busy has no effect on the stream.

Source files
------------

// File: rtl/aes_key_expand_serial.sv
// Byte-serial AES-128/192/256 key schedule: key bytes pass straight through,
// then every expanded round-key byte is streamed with ready/valid flow control.
module aes_key_expand_serial #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RND_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [7:0]       key_in,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [7:0]       rk_data,
  output logic [RND_W-1:0] rk_round,
  output logic [3:0]       rk_byte,
  output logic             rk_last,
  output logic             busy
);

  localparam int WIN_B  = MAX_KEY_BITS / 8;
  localparam int WIN_AW = $clog2(WIN_B);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       nk_q, nk_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [3:0]       byte_q, byte_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [7:0]       rk_data_q, rk_data_d;
  logic [7:0]       win_q [WIN_B];
  logic [7:0]       win_d [WIN_B];

  logic             in_load, in_exp, xfer, word_end, last_byte, nk_word_end;
  logic [RND_W-1:0] nr;
  logic [7:0]       in_byte, sb_in, sb_out, t_byte, old_byte;
  logic [WIN_AW-1:0] old_idx;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    logic [3:0] n;
    case (kl)
      2'd1:    n = (MAX_KEY_BITS >= 192) ? 4'd6 : 4'd4;
      2'd2:    n = (MAX_KEY_BITS >= 256) ? 4'd8 : 4'd4;
      default: n = 4'd4;
    endcase
    return n;
  endfunction

  assign in_load     = (state_q == S_LOAD);
  assign in_exp      = (state_q == S_EXPAND);
  assign xfer        = (in_load && key_valid && rk_ready) || (in_exp && rk_ready);
  assign word_end    = (byte_q[1:0] == 2'd3);
  assign nk_word_end = word_end && ({1'b0, wcnt_q} == (nk_q - 4'd1));
  assign nr          = RND_W'(nk_q) + RND_W'(6);
  assign last_byte   = in_exp && (round_q == nr) && (byte_q == 4'd15);
  assign in_byte     = in_load ? key_in : rk_data_q;

  always_comb begin
    state_d   = state_q;
    nk_d      = nk_q;
    wcnt_d    = wcnt_q;
    byte_d    = byte_q;
    round_d   = round_q;
    rcon_d    = rcon_q;
    win_d     = win_q;
    rk_data_d = rk_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nk_d    = nk_of(key_len);
          wcnt_d  = 3'd0;
          byte_d  = 4'd0;
          round_d = '0;
          rcon_d  = 8'h01;
          state_d = S_LOAD;
        end
      end
      S_LOAD, S_EXPAND: begin
        if (xfer) begin
          win_d[0] = in_byte;
          for (int k = 1; k < WIN_B; k++) win_d[k] = win_q[k-1];
          byte_d = byte_q + 4'd1;
          if (byte_q == 4'd15) round_d = round_q + RND_W'(1);
          if (word_end) wcnt_d = nk_word_end ? 3'd0 : wcnt_q + 3'd1;
          if (in_exp && word_end && (wcnt_q == 3'd0)) rcon_d = xtime(rcon_q);
          if (in_load && nk_word_end) state_d = S_EXPAND;
          if (last_byte) begin
            state_d = S_IDLE;
            wcnt_d  = 3'd0;
            byte_d  = 4'd0;
            round_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Next expanded byte, derived from the window as it will look after this transfer.
    // With most recent byte at index 0: w[i-1][j] sits at 3, RotWord source at 2 (or 6 for j=3).
    old_idx  = WIN_AW'({nk_d, 2'b00} - 6'd1);
    old_byte = win_d[old_idx];
    if (wcnt_d == 3'd0) sb_in = (byte_d[1:0] == 2'd3) ? win_d[6] : win_d[2];
    else                sb_in = win_d[3];
    sb_out = sbox(sb_in);
    if (wcnt_d == 3'd0)                          t_byte = sb_out ^ ((byte_d[1:0] == 2'd0) ? rcon_d : 8'h00);
    else if ((nk_d == 4'd8) && (wcnt_d == 3'd4)) t_byte = sb_out;
    else                                         t_byte = win_d[3];
    if (xfer && !last_byte) rk_data_d = old_byte ^ t_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nk_q      <= 4'd4;
      wcnt_q    <= 3'd0;
      byte_q    <= 4'd0;
      round_q   <= '0;
      rcon_q    <= 8'h01;
      rk_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      nk_q      <= nk_d;
      wcnt_q    <= wcnt_d;
      byte_q    <= byte_d;
      round_q   <= round_d;
      rcon_q    <= rcon_d;
      rk_data_q <= rk_data_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign key_ready = in_load && rk_ready;
  assign rk_valid  = in_load ? key_valid : in_exp;
  assign rk_data   = in_load ? key_in : rk_data_q;
  assign rk_round  = round_q;
  assign rk_byte   = byte_q;
  assign rk_last   = last_byte;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_key_expand_serial.sv
// Scoreboard bench for aes_key_expand_serial: word-level FIPS-197 reference model,
// random flow control, mid-job reset and ignored-start scenarios.
module tb_aes_key_expand_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] key_len = 2'd0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [7:0] key_in = 8'h00;
  logic       rk_valid;
  logic       rk_ready = 1'b1;
  logic [7:0] rk_data;
  logic [3:0] rk_round;
  logic [3:0] rk_byte;
  logic       rk_last;
  logic       busy;

  always #5 clk = ~clk;

  aes_key_expand_serial #(.MAX_KEY_BITS(256), .RND_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_round(rk_round), .rk_byte(rk_byte), .rk_last(rk_last), .busy(busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] r;
    logic [3:0] b;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] sbox_t [256];
  logic [7:0] kbuf [32];
  logic [7:0] mbytes [240];
  logic [7:0] cap [256];
  int         mon_cnt = 0;
  int         last_cnt = 0;
  int         cyc = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  int         job_nk = 4;
  bit         rmode = 1'b0;
  bit         prev_stall = 1'b0;
  bit         after_last = 1'b0;
  logic [7:0] pd;
  logic [3:0] pr, pb;
  logic       pl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: brute-force inverse, then the FIPS affine map bit by bit.
  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r = 8'h01;
    for (int i = 1; i < n; i++) r = xt(r);
    return r;
  endfunction

  task automatic ref_model(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    int nw;
    nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = {kbuf[4*i], kbuf[4*i+1], kbuf[4*i+2], kbuf[4*i+3]};
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++)
      for (int j = 0; j < 4; j++) mbytes[4*i+j] = w[i][31-8*j -: 8];
  endtask

  task automatic set_key(input logic [255:0] k);
    for (int i = 0; i < 32; i++) kbuf[i] = k[255-8*i -: 8];
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      after_last = 1'b0;
    end else begin
      if (!busy) mon_cnt = 0;
      if (after_last) begin
        chk("idle_after_last", 32'({busy, rk_valid}), 32'd0);
        after_last = 1'b0;
      end
      if (prev_stall)
        chk("stall_hold", 32'({rk_valid, rk_data, rk_round, rk_byte, rk_last}), 32'({1'b1, pd, pr, pb, pl}));
      if (busy && mon_cnt < 4 * job_nk) chk("key_ready_load", 32'(key_ready), 32'(rk_ready));
      else                              chk("key_ready_off", 32'(key_ready), 32'd0);
      if (rk_valid && rk_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_byte: got data %02h idx %0d, expected no output", rk_data, mon_cnt);
        end else begin
          total--;
          e = exp_q.pop_front();
          chk("stream", 32'({rk_data, rk_round, rk_byte, rk_last}), 32'(e));
        end
        if (mon_cnt < 256) cap[mon_cnt] = rk_data;
        if (mon_cnt == 0) first_cyc = cyc;
        if (rk_last) begin
          last_cyc = cyc;
          last_cnt++;
          after_last = 1'b1;
        end
        mon_cnt++;
      end
      prev_stall = rk_valid && !rk_ready;
      pd = rk_data;
      pr = rk_round;
      pb = rk_byte;
      pl = rk_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rk_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic feed_key(input int n, input bit gaps);
    int k = 0;
    int g = 0;
    bit took;
    while (k < n && g < 4000) begin
      if (!key_valid && (!gaps || $urandom_range(0, 2) != 0)) begin
        key_valid = 1'b1;
        key_in    = kbuf[k];
      end
      @(negedge clk);
      took = key_valid && key_ready;
      @(posedge clk);
      #1;
      if (took) begin
        k++;
        key_valid = 1'b0;
      end
      g++;
    end
    chk("key_feed", 32'(k), 32'(n));
    key_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int n);
    int g = 0;
    while (mon_cnt < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("reach_cnt", 32'(mon_cnt >= n), 32'd1);
  endtask

  task automatic run_job(input logic [1:0] kl, input bit gaps, input bit rnd, input bit full,
                         input bit poke, input int abort_at);
    int nk, nb, lc0, g;
    exp_t e;
    nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
    nb = 16 * (nk + 7);
    ref_model(nk);
    for (int i = 0; i < nb; i++) begin
      e.d = mbytes[i];
      e.r = 4'(i / 16);
      e.b = 4'(i % 16);
      e.l = (i == nb - 1);
      exp_q.push_back(e);
    end
    job_nk = nk;
    rmode  = rnd;
    lc0    = last_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    key_len = kl;
    @(posedge clk); #1;
    start = 1'b0;
    feed_key(4 * nk, gaps);
    if (poke) begin
      wait_cnt(60);
      @(posedge clk); #1;
      start = 1'b1; key_len = 2'd2; key_valid = 1'b1; key_in = 8'hee;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0; key_valid = 1'b0;
    end
    if (abort_at > 0) begin
      wait_cnt(abort_at);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy_vld", 32'({busy, rk_valid}), 32'd0);
      exp_q.delete();
      repeat (4) @(negedge clk);
      chk("rst_stays_idle", 32'({busy, rk_valid}), 32'd0);
    end else begin
      g = 0;
      while (last_cnt == lc0 && g < 3000) begin
        @(negedge clk);
        g++;
      end
      chk("job_done", 32'(last_cnt - lc0), 32'd1);
      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      if (full) chk("cycles", 32'(last_cyc - first_cyc + 1), 32'(nb));
    end
    rmode = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_key_ready", 32'(key_ready), 32'd0);
    chk("rst_rk_valid", 32'(rk_valid), 32'd0);
    chk("rst_rk_last", 32'(rk_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rk_data", 32'(rk_data), 32'd0);
    chk("rst_rk_round", 32'(rk_round), 32'd0);
    chk("rst_rk_byte", 32'(rk_byte), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    run_job(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t1_b16", {cap[16], cap[17], cap[18], cap[19]}, 32'ha0fafe17);
    chk("t1_b172", {cap[172], cap[173], cap[174], cap[175]}, 32'hb6630ca6);

    set_key({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
    run_job(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t2_b24", {cap[24], cap[25], cap[26], cap[27]}, 32'hfe0c91f7);
    chk("t2_b204", {cap[204], cap[205], cap[206], cap[207]}, 32'h01002202);

    set_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    run_job(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t3_b32", {cap[32], cap[33], cap[34], cap[35]}, 32'h9ba35411);
    chk("t3_b236", {cap[236], cap[237], cap[238], cap[239]}, 32'h706c631e);

    set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    run_job(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("t4_b172", {cap[172], cap[173], cap[174], cap[175]}, 32'hb6630ca6);

    set_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    run_job(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    run_job(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("t5_b32", {cap[32], cap[33], cap[34], cap[35]}, 32'h9ba35411);
    chk("t5_b236", {cap[236], cap[237], cap[238], cap[239]}, 32'h706c631e);

    set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    run_job(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    chk("t6_b16", {cap[16], cap[17], cap[18], cap[19]}, 32'ha0fafe17);
    chk("t6_b172", {cap[172], cap[173], cap[174], cap[175]}, 32'hb6630ca6);
    repeat (3) @(negedge clk);
    chk("t6_no_restart", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
